// File: rtl/mm_xfer.sv
// mm_xfer: converts 256-bit cache line read/write commands into eight 32-bit
// request/acknowledge beats on a word-wide memory port, with a per-beat
// acknowledge timeout and a sticky error flag.
module mm_xfer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mm_a,
    input  logic [255:0] mm_wd,
    input  logic         mm_write,
    input  logic         mm_read,
    output logic [255:0] mm_rd,
    output logic         mm_valid,
    output logic         mm_wr_done,
    output logic         mm_busy,
    output logic         mm_err,
    output logic [31:0]  mem_a,
    output logic [31:0]  mem_wd,
    output logic         mem_we,
    output logic         mem_req,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rd
);

    localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StDoneRd,
        StDoneWr
    } state_e;

    state_e         state_q, state_d;
    logic [26:0]    line_q, line_d;
    logic [255:0]   wd_q, wd_d;
    logic [255:0]   rd_q, rd_d;
    logic [2:0]     k_q, k_d;
    logic [15:0]    wait_q, wait_d;
    logic           err_q, err_d;
    logic [15:0]    wait_inc;
    logic [7:0]     word_lsb;

    assign wait_inc = wait_q + 16'd1;
    assign word_lsb = {k_q, 5'b00000};

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            line_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state, beat sequencing and memory-port outputs.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        k_d     = k_q;
        wait_d  = wait_q;
        err_d   = err_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;

        unique case (state_q)
            StIdle: begin
                k_d    = '0;
                wait_d = '0;
                if (mm_write) begin
                    // Write wins a simultaneous read; the read is dropped and flagged.
                    line_d  = mm_a[31:5];
                    wd_d    = mm_wd;
                    state_d = StWr;
                    if (mm_read) begin
                        err_d = 1'b1;
                    end
                end else if (mm_read) begin
                    line_d  = mm_a[31:5];
                    state_d = StRd;
                end
            end
            StRd, StWr: begin
                mem_req = 1'b1;
                mem_a   = {line_q, k_q, 2'b00};
                if (state_q == StWr) begin
                    mem_we = 1'b1;
                    mem_wd = wd_q[word_lsb +: 32];
                end
                if (mem_ack) begin
                    wait_d = '0;
                    k_d    = k_q + 3'd1;
                    if (state_q == StRd) begin
                        rd_d[word_lsb +: 32] = mem_rd;
                    end
                    if (k_q == 3'd7) begin
                        state_d = (state_q == StRd) ? StDoneRd : StDoneWr;
                    end
                end else if (wait_inc == TimeoutW) begin
                    // Give up on this beat: partial read words stay in mm_rd.
                    wait_d  = wait_inc;
                    err_d   = 1'b1;
                    k_d     = '0;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDoneRd, StDoneWr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mm_rd      = rd_q;
    assign mm_valid   = (state_q == StDoneRd);
    assign mm_wr_done = (state_q == StDoneWr);
    assign mm_busy    = (state_q != StIdle);
    assign mm_err     = err_q;

endmodule

// File: tb/tb_mm_xfer.sv
// Directed self-checking bench for mm_xfer (instantiated with TIMEOUT = 4).
module tb_mm_xfer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  mm_a = '0;
    logic [255:0] mm_wd = '0;
    logic         mm_write = 1'b0;
    logic         mm_read = 1'b0;
    logic [255:0] mm_rd;
    logic         mm_valid, mm_wr_done, mm_busy, mm_err;
    logic [31:0]  mem_a, mem_wd;
    logic         mem_we, mem_req;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rd = '0;

    int n_cmp = 0;
    int n_err = 0;

    mm_xfer #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mm_a       (mm_a),
        .mm_wd      (mm_wd),
        .mm_write   (mm_write),
        .mm_read    (mm_read),
        .mm_rd      (mm_rd),
        .mm_valid   (mm_valid),
        .mm_wr_done (mm_wr_done),
        .mm_busy    (mm_busy),
        .mm_err     (mm_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line whose word k is base + k.
    function automatic logic [255:0] ramp(input logic [31:0] base);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = base + 32'(k);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({mm_valid, mm_wr_done, mm_busy, mm_err, mem_we, mem_req} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {mm_valid, mm_wr_done, mm_busy, mm_err, mem_we, mem_req});
        end
        n_cmp++;
        if (mm_rd !== 256'd0) begin
            n_err++;
            $display("FAIL reset_mm_rd: got %h want 0", mm_rd);
        end
        n_cmp++;
        if ({mem_a, mem_wd} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got %h want 0", {mem_a, mem_wd});
        end
    endtask

    // Line read with ack every cycle; returns after the cycle following the pulse.
    task automatic read_line(input string tag, input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] line_a;
        line_a   = {addr[31:5], 5'b0};
        mm_a     = addr;
        mm_read  = 1'b1;
        tick();                       // command cycle C ends here
        mm_read  = 1'b0;
        mem_ack  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_rd = base + 32'(k);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_a !== line_a + 32'(4 * k)) begin
                n_err++;
                $display("FAIL %s_beat%0d: got req=%b we=%b a=%h want req=1 we=0 a=%h",
                         tag, k, mem_req, mem_we, mem_a, line_a + 32'(4 * k));
            end
            tick();
        end
        mem_ack = 1'b0;
        mem_rd  = '0;
        n_cmp++;
        if (mm_valid !== 1'b1 || mm_wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pulse_c9: got valid=%b wr_done=%b want 1 0", tag, mm_valid, mm_wr_done);
        end
        n_cmp++;
        if (mm_rd !== ramp(base)) begin
            n_err++;
            $display("FAIL %s_data: got %h want %h", tag, mm_rd, ramp(base));
        end
        tick();
        n_cmp++;
        if (mm_busy !== 1'b0 || mm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_c10: got busy=%b valid=%b want 0 0", tag, mm_busy, mm_valid);
        end
    endtask

    task automatic test_read();
        read_line("read", 32'h0001_2340, 32'h100);
        n_cmp++;
        if (mm_err !== 1'b0) begin
            n_err++;
            $display("FAIL read_err: got %b want 0", mm_err);
        end
    endtask

    // Back-to-back: command issued at C+10 of the previous read; mm_read pulsed while busy.
    task automatic test_busy_ignore();
        int pulses;
        pulses  = 0;
        mm_a    = 32'h0000_0400;
        mm_read = 1'b1;
        tick();
        mm_read = 1'b0;
        n_cmp++;
        if (mm_busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b want 1", mm_busy);
        end
        mem_ack = 1'b1;
        for (int c = 0; c < 14; c++) begin
            mem_rd  = 32'h200 + 32'(c);
            mm_read = (c >= 2 && c <= 4);
            if (mm_valid) pulses++;
            if (c == 8) mem_ack = 1'b0;
            tick();
        end
        mm_read = 1'b0;
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL busy_ignore_pulses: got %0d want 1", pulses);
        end
        n_cmp++;
        if (mm_rd !== ramp(32'h200) || mm_err !== 1'b0 || mm_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_state: got rd=%h err=%b busy=%b want rd=%h err=0 busy=0",
                     mm_rd, mm_err, mm_busy, ramp(32'h200));
        end
    endtask

    task automatic test_write_stalls();
        int stalls [8] = '{0, 3, 1, 2, 0, 3, 2, 1};
        int done_cnt;
        done_cnt = 0;
        mm_a     = 32'h0005_678C;     // low bits must be ignored
        mm_wd    = ramp(32'hA0);
        mm_write = 1'b1;
        tick();
        mm_write = 1'b0;
        mm_wd    = '0;
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s <= stalls[k]; s++) begin
                mem_ack = (s == stalls[k]);
                if (mm_wr_done) done_cnt++;
                n_cmp++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wd !== 32'hA0 + 32'(k) ||
                    mem_a !== 32'h0005_6780 + 32'(4 * k)) begin
                    n_err++;
                    $display("FAIL wr_beat%0d_s%0d: got req=%b we=%b wd=%h a=%h want 1 1 %h %h",
                             k, s, mem_req, mem_we, mem_wd, mem_a, 32'hA0 + 32'(k),
                             32'h0005_6780 + 32'(4 * k));
                end
                tick();
            end
        end
        mem_ack = 1'b0;
        if (mm_wr_done) done_cnt++;
        n_cmp++;
        if (mm_wr_done !== 1'b1 || mm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_pulse: got wr_done=%b valid=%b want 1 0", mm_wr_done, mm_valid);
        end
        tick();
        if (mm_wr_done) done_cnt++;
        n_cmp++;
        if (done_cnt !== 1 || mm_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_done_count: got %0d busy=%b want 1 busy=0", done_cnt, mm_busy);
        end
        n_cmp++;
        if (mm_rd !== ramp(32'h200)) begin
            n_err++;
            $display("FAIL wr_keeps_mm_rd: got %h want %h", mm_rd, ramp(32'h200));
        end
    endtask

    task automatic test_conflict();
        int valid_cnt;
        valid_cnt = 0;
        mm_a      = 32'h0009_9900;
        mm_wd     = ramp(32'h50);
        mm_write  = 1'b1;
        mm_read   = 1'b1;
        tick();
        mm_write  = 1'b0;
        mm_read   = 1'b0;
        mem_ack   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (mem_we !== 1'b1 || mem_wd !== 32'h50 + 32'(k)) begin
                n_err++;
                $display("FAIL conflict_beat%0d: got we=%b wd=%h want 1 %h",
                         k, mem_we, mem_wd, 32'h50 + 32'(k));
            end
            if (mm_valid) valid_cnt++;
            tick();
        end
        mem_ack = 1'b0;
        if (mm_valid) valid_cnt++;
        n_cmp++;
        if (mm_wr_done !== 1'b1 || mm_err !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_done: got wr_done=%b err=%b want 1 1", mm_wr_done, mm_err);
        end
        tick();
        if (mm_valid) valid_cnt++;
        n_cmp++;
        if (valid_cnt !== 0 || mm_err !== 1'b1 || mm_busy !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_after: got valid_cnt=%0d err=%b busy=%b want 0 1 0",
                     valid_cnt, mm_err, mm_busy);
        end
    endtask

    task automatic test_reset_mid();
        mm_a    = 32'h0001_2340;
        mm_read = 1'b1;
        tick();
        mm_read = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_rd = 32'h300 + 32'(k);
            tick();
        end
        n_cmp++;
        if (mem_a !== 32'h0001_2354 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_beat5: got a=%h req=%b want 00012354 1", mem_a, mem_req);
        end
        mem_rd = 32'h305;
        reset  = 1'b1;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || mm_busy !== 1'b0 || mm_valid !== 1'b0 || mm_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_abort: got req=%b busy=%b valid=%b err=%b want 0 0 0 0",
                     mem_req, mm_busy, mm_valid, mm_err);
        end
        n_cmp++;
        if (mm_rd !== 256'd0) begin
            n_err++;
            $display("FAIL rstmid_mm_rd: got %h want 0", mm_rd);
        end
        read_line("rstmid_reread", 32'h0001_2340, 32'h400);
    endtask

    task automatic test_timeout();
        int valid_cnt;
        logic [255:0] exp_rd;
        valid_cnt = 0;
        exp_rd    = ramp(32'h400);
        exp_rd[31:0]  = 32'h500;
        exp_rd[63:32] = 32'h501;
        mm_a    = 32'h0000_1000;
        mm_read = 1'b1;
        tick();
        mm_read = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem_rd = 32'h500 + 32'(k);
            tick();
        end
        mem_ack = 1'b0;
        mem_rd  = 32'hDEAD_BEEF;
        for (int w = 0; w < 4; w++) begin
            n_cmp++;
            if (mem_req !== 1'b1 || mem_a !== 32'h0000_1008) begin
                n_err++;
                $display("FAIL timeout_wait%0d: got req=%b a=%h want 1 00001008", w, mem_req, mem_a);
            end
            tick();
        end
        n_cmp++;
        if (mem_req !== 1'b0 || mm_busy !== 1'b0 || mm_err !== 1'b1 || mm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_abort: got req=%b busy=%b err=%b valid=%b want 0 0 1 0",
                     mem_req, mm_busy, mm_err, mm_valid);
        end
        n_cmp++;
        if (mm_rd !== exp_rd) begin
            n_err++;
            $display("FAIL timeout_partial: got %h want %h", mm_rd, exp_rd);
        end
        // Stray ack with no request outstanding must be ignored.
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (mm_valid || mm_busy) valid_cnt++;
            tick();
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (valid_cnt !== 0 || mm_err !== 1'b1 || mm_rd !== exp_rd) begin
            n_err++;
            $display("FAIL stray_ack: got activity=%0d err=%b want 0 err=1 rd unchanged",
                     valid_cnt, mm_err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_busy_ignore();
        test_write_stalls();
        test_conflict();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mm_xfer.md
MM_XFER -- requirements
Module: mm_xfer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles mem_req may wait for mem_ack on one beat (1..65535).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 mm_a  in  32  line address from cache; bits [4:0] ignored.
REQ-006 mm_wd  in  256  eviction line data; word k = bits [32k+31:32k].
REQ-007 mm_write  in  1  line write command.
REQ-008 mm_read  in  1  line fill command.
REQ-009 mm_rd  out  256  assembled fill line.
REQ-010 mm_valid  out  1  one-cycle pulse; mm_rd valid.
REQ-011 mm_wr_done  out  1  one-cycle pulse; line write complete.
REQ-012 mm_busy  out  1  high whenever state != IDLE.
REQ-013 mm_err  out  1  sticky error flag (timeout or conflicting command).
REQ-014 mem_a  out  32  word address of current beat.
REQ-015 mem_wd  out  32  write data of current beat.
REQ-016 mem_we  out  1  current beat is a write.
REQ-017 mem_req  out  1  beat request; held until acked.
REQ-018 mem_ack  in  1  beat accepted; for reads mem_rd valid same cycle.
REQ-019 mem_rd  in  32  read data of current beat.

Function
REQ-020 States SHALL be IDLE, RD, WR, DONE_RD, DONE_WR.
REQ-021 In IDLE with mm_write=1, SHALL latch mm_a[31:5] and mm_wd and go to WR; with only mm_read=1, SHALL latch mm_a[31:5] and go to RD.
REQ-022 Commands SHALL be sampled only in IDLE; commands while mm_busy=1 are ignored, with no error.
REQ-023 If mm_read and mm_write are both high in IDLE, write SHALL win, read is dropped, and mm_err SHALL set.
REQ-024 Beat counter k SHALL be 3 bits, ascending 0..7; mem_a = {line_addr[31:5], k, 2'b00}.
REQ-025 In RD/WR, mem_req SHALL be 1; mem_we=1 only in WR; mem_wd = latched word k in WR and 0 in RD.
REQ-026 mem_a, mem_wd and mem_we SHALL be stable while mem_req=1 and mem_ack=0.
REQ-027 On a cycle with mem_req & mem_ack, k SHALL increment; in RD, mem_rd SHALL be written into mm_rd[32k+31:32k].
REQ-028 Back-to-back acks SHALL give one beat per cycle; mem_req stays high between beats.
REQ-029 When beat 7 is acked, SHALL go to DONE_RD (mm_valid=1) or DONE_WR (mm_wr_done=1), then to IDLE next cycle.
REQ-030 Latency with ack every cycle: command cycle C, beats C+1..C+8, pulse C+9, mm_busy low and a new command acceptable at C+10.
REQ-031 mm_rd SHALL hold its value until overwritten by the next read; a write transfer SHALL not modify mm_rd.
REQ-032 Wait counter SHALL clear on each ack and on entering RD/WR, and increment each cycle mem_req=1 & mem_ack=0.
REQ-033 When the wait counter reaches TIMEOUT, SHALL deassert mem_req next cycle, set mm_err, go to IDLE, and emit no mm_valid/mm_wr_done.
REQ-034 After a timeout, mm_rd words already written SHALL be kept.
REQ-035 mem_ack while mem_req=0 SHALL be ignored.
REQ-036 mm_err SHALL clear only on reset.

Reset
REQ-037 On reset: state IDLE, k=0, wait counter 0, and outputs mm_rd, mm_valid, mm_wr_done, mm_busy, mm_err, mem_a, mem_wd, mem_we and mem_req all 0.
REQ-038 Reset mid-transfer SHALL abort at that edge: mem_req=0 next cycle, partial line discarded, no completion pulse.

Verification
REQ-039 Read mm_a=0x0001_2340, mem_ack every cycle, mem_rd=0x100+k -> mem_a 0x12340..0x1235C, mm_valid at C+9, mm_rd word k = 0x100+k.
REQ-040 Write mm_wd word k=0xA0+k with random 0-3 cycle ack stalls -> mem_we=1 and mem_wd=0xA0+k stable through stalls; single mm_wr_done; mm_rd unchanged.
REQ-041 mm_read & mm_write together -> write-only transfer, mm_err=1, no mm_valid.
REQ-042 TIMEOUT=4, no ack on beat 2 -> mem_req low after 4 wait cycles, mm_err=1, IDLE, no mm_valid.
REQ-043 reset at beat 5 of a read -> next cycle mem_req=0, mm_busy=0, mm_rd=0; a new read then completes normally.
REQ-044 mm_read pulsed while mm_busy=1 -> ignored; exactly one mm_valid.
